fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Instruction-fetch front end for the 32-bit ARM-like core.
- Holds the PC internally and issues word reads to instruction memory over a req/ack handshake.
- Stores returned instructions, each tagged with its PC, in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- On a branch, drops both any in-flight read and all buffered instructions, then restarts fetch at the target.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  read request; held high until imem_ack.
- imem_addr  output  32  word-aligned read address; stable while imem_req=1.
- imem_ack  input  1  one-cycle pulse; read complete and imem_rdata valid in this cycle.
- imem_rdata  input  32  instruction word; sampled only when imem_ack=1.
- inst_valid  output  1  FIFO head holds a valid instruction.
- inst  output  32  instruction at the FIFO head.
- inst_pc  output  32  PC of the FIFO head instruction.
- inst_ready  input  1  decode accepts the head; pop when inst_valid & inst_ready.
- redirect  input  1  branch taken; flush and restart.
- redirect_pc  input  32  branch target; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset, synchronous:
  - pc=RESET_PC, FIFO empty, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- States:
  - IDLE: no read outstanding.
  - WAIT: read outstanding; its data will be kept.
  - DROP: read outstanding; its data will be discarded.
- imem_req and imem_addr are registered. imem_req=1 exactly in WAIT and DROP.
- Issue rule: IDLE->WAIT only when occupancy < DEPTH after this cycle's pop. On the transition, imem_addr is set to pc.
- Ack in WAIT:
  - Push {pc, imem_rdata} into the FIFO; pc<=pc+4, with 32-bit wrap (32'hFFFF_FFFC+4 = 0).
  - Go to IDLE, so req is low for one cycle. Peak throughput is one instruction per 2 cycles with 1-cycle memory.
- Ack in DROP: discard the data, set pc to the saved target, go to IDLE.
- imem_ack while in IDLE is ignored (protocol error, no state change).
- Redirect:
  - In IDLE: flush FIFO; pc<=redirect_pc; the next cycle may issue.
  - In WAIT without ack: flush FIFO; save the target; go to DROP. imem_req stays high with the old address until ack, because a request is never withdrawn.
  - In WAIT with ack in the same cycle: data is not pushed; flush; pc<=redirect_pc; go to IDLE.
  - In DROP: the saved target is overwritten with the newest redirect_pc; stay in DROP, or go to IDLE on ack.
  - Redirect takes priority over pop and push in the same cycle. inst_valid is 0 on the following cycle.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a count.
  - Simultaneous push and pop keeps count unchanged.
  - The issue rule guarantees a push never hits a full FIFO.
  - A pop when empty is ignored.
- Head outputs:
  - inst_valid = (count != 0).
  - inst and inst_pc come from the head entry when valid; otherwise they hold their last value.
  - These outputs are combinational from FIFO state only, not from inst_ready.
- Reset asserted mid-read returns to reset state. The memory is reset by the same signal, so no ack arrives for the cancelled read.

Optional Feature:
- FETCH_STATS_EN, defined:
  - Adds output stat_fetched[31:0], incremented on every FIFO push.
  - Adds output stat_dropped[31:0], incremented on every discarded ack plus every valid entry flushed by redirect.
  - Both counters reset to 0 and wrap.
- FETCH_STATS_EN undefined: neither port nor counters exist.

Test Plan:
- Reset then 1-cycle-latency memory returning addr^32'hA5A5_0000, inst_ready=1:
  - First imem_req has addr 0.
  - Decode sees (pc=0, inst=32'hA5A5_0000), then (4, 32'hA5A5_0004), (8, ...), spaced 2 cycles apart.
- inst_ready=0, DEPTH=4:
  - Exactly 4 reads complete and imem_req stays 0.
  - Raising inst_ready for 1 cycle gives one pop and exactly one new request, addr=32'h10.
- Memory latency 5 cycles; redirect_pc=32'h0000_0103 pulsed 2 cycles into a read:
  - imem_req stays high to ack and that data is never output.
  - The next request has addr=32'h100; first delivered inst_pc=32'h100.
- Redirect to 32'h200 in the same cycle as ack and as a pop with 2 entries buffered:
  - inst_valid=0 the next cycle; next request addr=32'h200.
- Two redirects during one outstanding read (32'h300, then 32'h400): next request addr=32'h400.
- Redirect to 32'hFFFF_FFF8, fetch 3: delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With FETCH_STATS_EN, after the third scenario: stat_dropped=1; stat_fetched counts only pushed words.

Source files
------------

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_buffer
//  Purpose  : Instruction-fetch front end. Owns the PC, issues word reads to
//             instruction memory over req/ack, queues returned words tagged
//             with their PC in a prefetch FIFO and hands them to decode over
//             valid/ready. A redirect flushes the queue and restarts fetch
//             at the branch target.
//  Options  : define FETCH_STATS_EN to add the stat_fetched / stat_dropped
//             event counters.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_dropped
`endif
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

    // IDLE: nothing outstanding; WAIT: outstanding read is kept;
    // DROP: outstanding read is discarded when it returns.
    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_wait = 2'd1;
    localparam logic [1:0] c_drop = 2'd2;

    logic [1:0]      r_state;
    logic [31:0]     r_pc;
    logic [31:0]     r_target;
    logic            r_req;
    logic [31:0]     r_addr;

    logic [31:0]     r_mem_inst [DEPTH];
    logic [31:0]     r_mem_pc   [DEPTH];
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_cw-1:0] r_count;
    logic [31:0]     r_last_inst;
    logic [31:0]     r_last_pc;

    logic [31:0]     w_redirect_pc;
    logic            w_push;
    logic            w_pop;
    logic            w_room;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_pop         = inst_valid & inst_ready;
    // A redirect coinciding with the ack wins: the returned word is stale.
    assign w_push        = (r_state == c_wait) & imem_ack & ~redirect;
    // Only issue if the word can be stored even if decode stalls from now on.
    assign w_room        = (r_count - c_cw'(w_pop)) < c_depth;

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign inst_valid = (r_count != '0);
    assign inst       = inst_valid ? r_mem_inst[r_rd_ptr] : r_last_inst;
    assign inst_pc    = inst_valid ? r_mem_pc[r_rd_ptr]   : r_last_pc;

    // Fetch sequencer: PC, redirect target and the registered request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_idle;
            r_pc     <= RESET_PC;
            r_target <= RESET_PC;
            r_req    <= 1'b0;
            r_addr   <= RESET_PC;
        end else begin
            case (r_state)
                c_idle: begin
                    if (redirect) begin
                        r_pc <= w_redirect_pc;
                    end else if (w_room) begin
                        r_state <= c_wait;
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                    end
                end
                c_wait: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            r_pc    <= w_redirect_pc;
                            r_state <= c_idle;
                            r_req   <= 1'b0;
                        end else begin
                            // Request cannot be withdrawn; keep it and discard its data.
                            r_target <= w_redirect_pc;
                            r_state  <= c_drop;
                        end
                    end else if (imem_ack) begin
                        r_pc    <= r_pc + 32'd4;
                        r_state <= c_idle;
                        r_req   <= 1'b0;
                    end
                end
                c_drop: begin
                    if (imem_ack) begin
                        r_pc    <= redirect ? w_redirect_pc : r_target;
                        r_state <= c_idle;
                        r_req   <= 1'b0;
                    end else if (redirect) begin
                        r_target <= w_redirect_pc;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; redirect flushes ahead of push/pop.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; entries need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_pc;
        end
    end

    // Remember the head so inst/inst_pc hold their last value when empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_inst <= 32'd0;
            r_last_pc   <= 32'd0;
        end else if (inst_valid) begin
            r_last_inst <= r_mem_inst[r_rd_ptr];
            r_last_pc   <= r_mem_pc[r_rd_ptr];
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_dropped;
    logic        w_discard;

    // Any ack whose data is thrown away, whether in DROP or killed by redirect.
    assign w_discard = imem_ack & ((r_state == c_drop) | ((r_state == c_wait) & redirect));

    // Wrapping event counters: pushed words and discarded/flushed words.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_fetched <= 32'd0;
            r_stat_dropped <= 32'd0;
        end else begin
            r_stat_fetched <= r_stat_fetched + 32'(w_push);
            r_stat_dropped <= r_stat_dropped + 32'(w_discard)
                              + (redirect ? 32'(r_count) : 32'd0);
        end
    end

    assign stat_fetched = r_stat_fetched;
    assign stat_dropped = r_stat_dropped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_buffer
//  Purpose  : Directed bench for fetch_buffer: per-cycle vector table for
//             streaming and back-pressure, hand sequences for redirects.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_dropped;
`endif

    fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched(stat_fetched),
        .stat_dropped(stat_dropped)
`endif
    );

    localparam logic [31:0] c_key = 32'hA5A5_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 1;
    int lat_cnt  = 0;
    bit mem_auto = 1'b1;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] ins;
        logic [31:0] ipc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic rdy, logic req, logic [31:0] addr,
                                logic v, logic [31:0] ins, logic [31:0] ipc);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.req = req; r.addr = addr;
        r.v = v; r.ins = ins; r.ipc = ipc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: memory model acts at the falling edge, outputs are
    // observed 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (reset) begin
            lat_cnt = 0;
            if (mem_auto) imem_ack = 1'b0;
        end else if (mem_auto) begin
            imem_ack = 1'b0;
            if (imem_req) begin
                lat_cnt++;
                if (lat_cnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem_addr ^ c_key;
                    lat_cnt    = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        redirect   = 1'b0;
        inst_ready = 1'b0;
        imem_ack   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;

        // Streaming with a 1-cycle memory and decode always ready.
        tbl.push_back(mk(1, 1, 0, 32'h0, 0, 32'h0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0, 0, 32'h0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 32'h0, 0, 32'h0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0, 1, 32'hA5A5_0000, 32'h0));
        tbl.push_back(mk(0, 1, 1, 32'h4, 0, 32'hA5A5_0000, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h4, 1, 32'hA5A5_0004, 32'h4));
        tbl.push_back(mk(0, 1, 1, 32'h8, 0, 32'hA5A5_0004, 32'h4));
        tbl.push_back(mk(0, 1, 0, 32'h8, 1, 32'hA5A5_0008, 32'h8));
        // Back-pressure from reset: four reads fill the FIFO, then it stalls.
        tbl.push_back(mk(1, 0, 0, 32'h0, 0, 32'h0, 32'h0));
        tbl.push_back(mk(0, 0, 1, 32'h0, 0, 32'h0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0, 1, 32'hA5A5_0000, 32'h0));
        tbl.push_back(mk(0, 0, 1, 32'h4, 1, 32'hA5A5_0000, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h4, 1, 32'hA5A5_0000, 32'h0));
        tbl.push_back(mk(0, 0, 1, 32'h8, 1, 32'hA5A5_0000, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h8, 1, 32'hA5A5_0000, 32'h0));
        tbl.push_back(mk(0, 0, 1, 32'hC, 1, 32'hA5A5_0000, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'hC, 1, 32'hA5A5_0000, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'hC, 1, 32'hA5A5_0000, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'hC, 1, 32'hA5A5_0000, 32'h0));
        // One-cycle pop frees one slot: exactly one new request at 0x10.
        tbl.push_back(mk(0, 1, 1, 32'h10, 1, 32'hA5A5_0004, 32'h4));
        tbl.push_back(mk(0, 0, 0, 32'h10, 1, 32'hA5A5_0004, 32'h4));
        tbl.push_back(mk(0, 0, 0, 32'h10, 1, 32'hA5A5_0004, 32'h4));
        tbl.push_back(mk(0, 0, 0, 32'h10, 1, 32'hA5A5_0004, 32'h4));

        mem_auto = 1'b1;
        mem_lat  = 1;
        foreach (tbl[i]) begin
            reset      = tbl[i].rst;
            inst_ready = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d", i),
                {29'd0, imem_req, imem_addr, inst_valid, inst, inst_pc},
                {29'd0, tbl[i].req, tbl[i].addr, tbl[i].v, tbl[i].ins, tbl[i].ipc});
        end

        // Redirect two cycles into a 5-cycle read: read completes, data dropped.
        mem_lat = 5;
        do_reset();
        inst_ready = 1'b1;
        tick();
        chk("s3_first_req", {imem_req, imem_addr}, {1'b1, 32'h0});
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("s3_req_held%0d", k), {imem_req, imem_addr, inst_valid}, {1'b1, 32'h0, 1'b0});
            tick();
        end
        tick();
        chk("s3_after_drop", {imem_req, inst_valid}, {1'b0, 1'b0});
        tick();
        chk("s3_new_req", {imem_req, imem_addr}, {1'b1, 32'h100});
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("s3_no_data%0d", k), {31'd0, inst_valid}, 32'd0);
        end
        tick();
        chk("s3_first_pc", {inst_valid, inst_pc, inst}, {1'b1, 32'h100, 32'hA5A5_0100});
`ifdef FETCH_STATS_EN
        chk("s3_stats", {stat_fetched, stat_dropped}, {32'd1, 32'd1});
`endif

        // Redirect coinciding with ack and pop while two entries are queued.
        mem_lat = 1;
        do_reset();
        mem_auto = 1'b0;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h1111_0000;
        tick();
        imem_ack = 1'b0;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h2222_0004;
        tick();
        imem_ack = 1'b0;
        chk("s4_two_queued", {inst_valid, inst_pc, inst}, {1'b1, 32'h0, 32'h1111_0000});
        tick();
        chk("s4_third_req", {imem_req, imem_addr}, {1'b1, 32'h8});
        imem_ack = 1'b1; imem_rdata = 32'h3333_0008;
        inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        imem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
        chk("s4_flushed", {imem_req, inst_valid}, {1'b0, 1'b0});
`ifdef FETCH_STATS_EN
        chk("s4_stats", {stat_fetched, stat_dropped}, {32'd2, 32'd3});
`endif
        tick();
        chk("s4_new_req", {imem_req, imem_addr}, {1'b1, 32'h200});

        // Two redirects during one outstanding read: the newest target wins.
        do_reset();
        inst_ready = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        tick();
        chk("s5_req_kept", {imem_req, imem_addr}, {1'b1, 32'h0});
        redirect_pc = 32'h0000_0400;
        tick();
        redirect = 1'b0;
        tick();
        chk("s5_still_kept", {imem_req, imem_addr}, {1'b1, 32'h0});
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("s5_ack_done", {imem_req, inst_valid}, {1'b0, 1'b0});
        tick();
        chk("s5_new_req", {imem_req, imem_addr}, {1'b1, 32'h400});

        // PC wraps from the top of the address space.
        mem_auto = 1'b1;
        mem_lat  = 1;
        do_reset();
        inst_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        chk("s6_no_issue", {31'd0, imem_req}, 32'd0);
        tick();
        chk("s6_req", {imem_req, imem_addr}, {1'b1, 32'hFFFF_FFF8});
        tick();
        chk("s6_pc0", {inst_valid, inst_pc, inst}, {1'b1, 32'hFFFF_FFF8, 32'h5A5A_FFF8});
        tick();
        tick();
        chk("s6_pc1", {inst_valid, inst_pc, inst}, {1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC});
        tick();
        tick();
        chk("s6_pc2", {inst_valid, inst_pc, inst}, {1'b1, 32'h0000_0000, 32'hA5A5_0000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
